openeth_wb2avm: RTL and testbench

OPENETH_WB2AVM -- requirements
Module: openeth_wb2avm

---
 rtl/openeth_wb2avm.sv | 136 +++++++++++++
 tb/tb_openeth_wb2avm.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/openeth_wb2avm.sv
`default_nettype none
// ============================================================================
// Module      : openeth_wb2avm
// Description : Wishbone slave to Avalon-MM master bridge for the Ethernet MAC
//               DMA port; one outstanding transfer, read timeout with error.
// Revision    : 1.0 - initial release
// ============================================================================
module openeth_wb2avm #(
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset_n,

   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:2] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,

   output logic [31:2] avm_address,
   output logic [3:0]  avm_byteenable,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_CMD  = 3'd2,
      RD_WAIT = 3'd3,
      ACK     = 3'd4,
      ERR     = 3'd5
   } state_t;

   localparam logic [9:0] c_tlimit = 10'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [31:2] r_adr;
   logic [3:0]  r_sel;
   logic [31:0] r_dat;
   logic [31:0] r_rdata;
   logic [9:0]  r_tcnt;
   logic        r_abort;
   logic        w_req;
   logic        w_abort;
   logic        w_busy;

   assign w_req   = wb_cyc_i & wb_stb_i;
   // An abandoned cycle is remembered so a long read still finishes silently
   assign w_abort = r_abort | ~wb_cyc_i;
   assign w_busy  = (r_state == WR) || (r_state == RD_CMD) || (r_state == RD_WAIT);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_req) begin
               w_next = wb_we_i ? WR : RD_CMD;
            end
         end
         WR: begin
            if (!avm_waitrequest) begin
               w_next = w_abort ? IDLE : ACK;
            end
         end
         RD_CMD: begin
            if (!avm_waitrequest) begin
               w_next = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (avm_readdatavalid) begin
               w_next = w_abort ? IDLE : ACK;
            end else if (r_tcnt == c_tlimit) begin
               w_next = w_abort ? IDLE : ERR;
            end
         end
         ACK:     w_next = IDLE;
         ERR:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_adr   <= '0;
         r_sel   <= '0;
         r_dat   <= '0;
         r_rdata <= '0;
         r_tcnt  <= '0;
         r_abort <= 1'b0;
      end else begin
         r_state <= w_next;
         r_abort <= w_busy ? w_abort : 1'b0;

         if ((r_state == IDLE) && w_req) begin
            r_adr <= wb_adr_i;
            r_sel <= wb_sel_i;
            r_dat <= wb_dat_i;
         end

         if ((r_state == RD_WAIT) && avm_readdatavalid) begin
            r_rdata <= avm_readdata;
         end

         // Counts consecutive RD_WAIT cycles; cleared on any other state
         if ((r_state == RD_WAIT) && (w_next == RD_WAIT)) begin
            r_tcnt <= r_tcnt + 10'd1;
         end else begin
            r_tcnt <= '0;
         end
      end
   end

   assign avm_address    = r_adr;
   assign avm_byteenable = r_sel;
   assign avm_writedata  = r_dat;
   assign avm_read       = (r_state == RD_CMD);
   assign avm_write      = (r_state == WR);

   assign wb_dat_o = r_rdata;
   assign wb_ack_o = (r_state == ACK);
   assign wb_err_o = (r_state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_openeth_wb2avm.sv
`default_nettype none
// Scoreboard bench for openeth_wb2avm: directed transfers, a scripted Avalon
// slave, and a monitor that checks every accepted command and every response.
module tb_openeth_wb2avm;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [31:2] wb_adr_i = '0;
   logic [3:0]  wb_sel_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o, wb_err_o;
   logic [31:2] avm_address;
   logic [3:0]  avm_byteenable;
   logic        avm_read, avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata = '0;
   logic        avm_waitrequest = 1'b0;
   logic        avm_readdatavalid = 1'b0;

   openeth_wb2avm #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
      .avm_readdatavalid(avm_readdatavalid)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      logic        we;
      logic [29:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      int          hold;
   } cmd_t;

   typedef struct {
      logic        is_err;
      logic        chk_dat;
      logic [31:0] dat;
      int          due;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Scripted Avalon slave: fixed waitrequest count per command, read data
   // returned rd_lat cycles after accept (0 = never), optional junk valid on accept
   int          wr_wait = 0;
   int          rd_lat = 1;
   int          wcnt = 0;
   int          pend = 0;
   logic [31:0] rd_data = '0;
   logic [31:0] pend_data = '0;
   logic        early_junk = 1'b0;

   always @(negedge clk) begin
      avm_readdatavalid = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = pend_data;
         end
      end
      if (avm_read || avm_write) begin
         if (wcnt < wr_wait) begin
            avm_waitrequest = 1'b1;
            wcnt++;
         end else begin
            avm_waitrequest = 1'b0;
            wcnt = 0;
            if (avm_read) begin
               if (rd_lat > 0) begin
                  pend = rd_lat;
                  pend_data = rd_data;
               end
               if (early_junk) begin
                  avm_readdatavalid = 1'b1;
                  avm_readdata = 32'hBADBAD00;
               end
            end
         end
      end else begin
         avm_waitrequest = 1'b0;
         wcnt = 0;
      end
   end

   // Monitor
   int run = 0;
   int n_cmd = 0;
   int n_rsp = 0;

   always begin : mon
      cmd_t c;
      rsp_t r;
      @(negedge clk);
      #2;
      if (!reset_n) begin
         run = 0;
      end else begin
         if (avm_read && avm_write) begin
            total++; bad++;
            $display("FAIL rw_excl: read=%b write=%b, required not both", avm_read, avm_write);
         end
         if (wb_ack_o && wb_err_o) begin
            total++; bad++;
            $display("FAIL ack_err_excl: ack=%b err=%b, required not both", wb_ack_o, wb_err_o);
         end
         if (avm_read || avm_write) begin
            run++;
            if (!avm_waitrequest) begin
               n_cmd++;
               if (cmd_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL cmd_unexpected: we=%b adr=%h at cycle %0d, required none",
                           avm_write, avm_address, cyc_cnt);
               end else begin
                  c = cmd_q.pop_front();
                  chk("cmd_we", {31'd0, avm_write}, {31'd0, c.we});
                  chk("cmd_adr", {2'd0, avm_address}, {2'd0, c.adr});
                  chk("cmd_sel", {28'd0, avm_byteenable}, {28'd0, c.sel});
                  if (c.we) chk("cmd_wdata", avm_writedata, c.dat);
                  chk("cmd_hold_cycles", run, c.hold);
               end
               run = 0;
            end
         end else begin
            run = 0;
         end
         if (wb_ack_o || wb_err_o) begin
            n_rsp++;
            if (rsp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL rsp_unexpected: ack=%b err=%b at cycle %0d, required none",
                        wb_ack_o, wb_err_o, cyc_cnt);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_err", {31'd0, wb_err_o}, {31'd0, r.is_err});
               chk("rsp_cycle", cyc_cnt, r.due);
               if (r.chk_dat) chk("rsp_rdata", wb_dat_o, r.dat);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
   endtask

   task automatic idle_bus();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic exp_cmd(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int hold);
      cmd_t c;
      c.we = we; c.adr = adr; c.sel = sel; c.dat = dat; c.hold = hold;
      cmd_q.push_back(c);
   endtask

   task automatic exp_rsp(input logic is_err, input logic chk_dat, input logic [31:0] dat,
                          input int lat);
      rsp_t r;
      r.is_err = is_err; r.chk_dat = chk_dat; r.dat = dat; r.due = cyc_cnt + lat;
      rsp_q.push_back(r);
   endtask

   // Waits for ack/err, then returns #1 after the following rising edge
   task automatic wait_resp(input string name);
      bit got = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (wb_ack_o || wb_err_o) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL %s_no_response: got none within 2000 cycles, required ack or err", name);
      end
      step(1);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_avm_read"}, {31'd0, avm_read}, 32'd0);
      chk({tag, "_avm_write"}, {31'd0, avm_write}, 32'd0);
      chk({tag, "_ack"}, {31'd0, wb_ack_o}, 32'd0);
      chk({tag, "_err"}, {31'd0, wb_err_o}, 32'd0);
      chk({tag, "_dat_o"}, wb_dat_o, 32'd0);
      chk({tag, "_address"}, {2'd0, avm_address}, 32'd0);
      chk({tag, "_byteenable"}, {28'd0, avm_byteenable}, 32'd0);
      chk({tag, "_writedata"}, avm_writedata, 32'd0);
   endtask

   int n0, r0;

   initial begin
      // Reset state
      step(3);
      @(negedge clk); #2;
      check_reset("rst");
      step(1);
      reset_n = 1'b1;
      step(2);

      // Single write, no waitrequest
      wr_wait = 0;
      drive(1'b1, 30'h40, 4'hF, 32'hDEADBEEF);
      exp_cmd(1'b1, 30'h40, 4'hF, 32'hDEADBEEF, 1);
      exp_rsp(1'b0, 1'b0, 32'd0, 2);
      wait_resp("wr_basic");
      idle_bus();
      step(2);

      // Read, slave latency 1
      wr_wait = 0; rd_lat = 1; rd_data = 32'hA5A50001;
      drive(1'b0, 30'h41, 4'hF, 32'd0);
      exp_cmd(1'b0, 30'h41, 4'hF, 32'd0, 1);
      exp_rsp(1'b0, 1'b1, 32'hA5A50001, 3);
      wait_resp("rd_basic");
      idle_bus();
      step(2);

      // Read with 3 waitrequest cycles and latency 2
      wr_wait = 3; rd_lat = 2; rd_data = 32'h12345678;
      drive(1'b0, 30'h0123456, 4'h5, 32'd0);
      exp_cmd(1'b0, 30'h0123456, 4'h5, 32'd0, 4);
      exp_rsp(1'b0, 1'b1, 32'h12345678, 7);
      wait_resp("rd_wait");
      idle_bus();
      step(2);

      // Junk readdatavalid alongside the accepted command must be ignored
      wr_wait = 0; rd_lat = 1; rd_data = 32'h5555AAAA; early_junk = 1'b1;
      drive(1'b0, 30'h77, 4'hF, 32'd0);
      exp_cmd(1'b0, 30'h77, 4'hF, 32'd0, 1);
      exp_rsp(1'b0, 1'b1, 32'h5555AAAA, 3);
      wait_resp("rd_early");
      idle_bus();
      early_junk = 1'b0;
      step(2);

      // Write, partial byteenable, top address, 2 wait cycles
      wr_wait = 2;
      drive(1'b1, 30'h3FFFFFFF, 4'h3, 32'h00C0FFEE);
      exp_cmd(1'b1, 30'h3FFFFFFF, 4'h3, 32'h00C0FFEE, 3);
      exp_rsp(1'b0, 1'b0, 32'd0, 4);
      wait_resp("wr_wait");
      idle_bus();
      step(2);

      // Read that never returns: err after TO RD_WAIT cycles
      wr_wait = 0; rd_lat = 0;
      drive(1'b0, 30'h88, 4'hF, 32'd0);
      exp_cmd(1'b0, 30'h88, 4'hF, 32'd0, 1);
      exp_rsp(1'b1, 1'b0, 32'd0, 2 + TO);
      wait_resp("rd_timeout");
      idle_bus();
      step(1);
      @(negedge clk); #2;
      chk("timeout_dat_hold", wb_dat_o, 32'h5555AAAA);
      step(2);

      // Back-to-back write then read with stb held high
      n0 = n_cmd; r0 = n_rsp;
      wr_wait = 0; rd_lat = 1; rd_data = 32'h33334444;
      drive(1'b1, 30'h10, 4'hF, 32'h11112222);
      exp_cmd(1'b1, 30'h10, 4'hF, 32'h11112222, 1);
      exp_rsp(1'b0, 1'b0, 32'd0, 2);
      wait_resp("b2b_wr");
      drive(1'b0, 30'h11, 4'hF, 32'd0);
      exp_cmd(1'b0, 30'h11, 4'hF, 32'd0, 1);
      exp_rsp(1'b0, 1'b1, 32'h33334444, 3);
      wait_resp("b2b_rd");
      idle_bus();
      step(4);
      chk("b2b_cmd_count", n_cmd - n0, 2);
      chk("b2b_ack_count", n_rsp - r0, 2);

      // Cycle dropped during WR: command completes, no ack
      n0 = n_cmd; r0 = n_rsp;
      wr_wait = 3;
      drive(1'b1, 30'h22, 4'hC, 32'h77778888);
      exp_cmd(1'b1, 30'h22, 4'hC, 32'h77778888, 4);
      step(1);
      idle_bus();
      wb_adr_i = '1; wb_sel_i = '0; wb_dat_i = '0;
      step(8);
      chk("wr_abort_cmd_count", n_cmd - n0, 1);
      chk("wr_abort_rsp_count", n_rsp - r0, 0);

      // Cycle dropped during RD_WAIT, response arrives after the timeout
      r0 = n_rsp;
      wr_wait = 0; rd_lat = 12; rd_data = 32'hBAD0BAD0;
      drive(1'b0, 30'h50, 4'hF, 32'd0);
      exp_cmd(1'b0, 30'h50, 4'hF, 32'd0, 1);
      step(3);
      idle_bus();
      step(16);
      chk("rdwait_abort_rsp_count", n_rsp - r0, 0);
      @(negedge clk); #2;
      chk("stale_dat_hold", wb_dat_o, 32'h33334444);
      step(1);
      rd_lat = 1; rd_data = 32'hCAFEF00D;
      drive(1'b0, 30'h51, 4'hF, 32'd0);
      exp_cmd(1'b0, 30'h51, 4'hF, 32'd0, 1);
      exp_rsp(1'b0, 1'b1, 32'hCAFEF00D, 3);
      wait_resp("after_stale");
      idle_bus();
      step(2);

      // Reset while RD_CMD is stalled
      wr_wait = 1000;
      drive(1'b0, 30'h60, 4'hF, 32'd0);
      step(3);
      reset_n = 1'b0;
      idle_bus();
      @(posedge clk);
      @(negedge clk); #2;
      check_reset("midrst");
      step(1);
      wr_wait = 0;
      reset_n = 1'b1;
      step(2);
      rd_lat = 1; rd_data = 32'h0F0E0D0C;
      drive(1'b0, 30'h61, 4'hA, 32'd0);
      exp_cmd(1'b0, 30'h61, 4'hA, 32'd0, 1);
      exp_rsp(1'b0, 1'b1, 32'h0F0E0D0C, 3);
      wait_resp("post_rst");
      idle_bus();
      step(4);

      chk("cmd_q_drained", cmd_q.size(), 0);
      chk("rsp_q_drained", rsp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
